// File: rtl/down_timer.sv
// -----------------------------------------------------------------------------
// down_timer
//
// Programmable down-counting timer. A start value N is loaded through a
// valid/ready handshake. The counter then decrements on every enabled cycle
// and emits a one-cycle terminal-count pulse when it expires. In one-shot
// mode the counter returns to IDLE after expiry. In periodic mode it reloads
// N and keeps running. Dropping enable pauses the count in HOLD. A new load
// may be accepted in IDLE or HOLD.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   sclr         synchronous clear, same effect as rst on the next edge
//   load_valid   start value offered
//   load_ready   block can accept a load (IDLE or HOLD)
//   load_value   start value N
//   periodic     sampled at load accept: 1 = auto-reload, 0 = one-shot
//   enable       count-enable qualifier
//   stop         abort the current count (reload/mode retained)
//   q            current count, registered
//   busy         high in RUN or HOLD
//   tc           terminal-count pulse, one cycle, registered
// -----------------------------------------------------------------------------
module down_timer #(
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclr,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_value,
    input  logic             periodic,
    input  logic             enable,
    input  logic             stop,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             tc
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] count_q,  count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             mode_q,   mode_d;
    logic             tc_q,     tc_d;
    logic             load_accept_s;

    // Handshake decodes straight from the state register.
    always_comb begin
        load_ready    = (state_q != ST_RUN);
        busy          = (state_q != ST_IDLE);
        load_accept_s = load_valid && (state_q != ST_RUN);
    end

    // Next-state computation in priority order: sclr > stop > load > count.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        tc_d     = 1'b0;

        if (sclr) begin
            state_d  = ST_IDLE;
            count_d  = CNT_ZERO;
            reload_d = CNT_ZERO;
            mode_d   = 1'b0;
        end else if (stop) begin
            // Abort wins over a would-be expiry; reload/mode are kept.
            state_d = ST_IDLE;
            count_d = CNT_ZERO;
        end else if (load_accept_s) begin
            // No decrement on the accepting edge; a pending expiry in HOLD
            // is simply discarded by the restart.
            state_d  = ST_RUN;
            count_d  = load_value;
            reload_d = load_value;
            mode_d   = periodic;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_RUN, ST_HOLD: begin
                    if (count_q == CNT_ZERO) begin
                        // A zero load expires immediately and never
                        // free-runs, whatever the mode.
                        tc_d    = 1'b1;
                        count_d = CNT_ZERO;
                        state_d = ST_IDLE;
                    end else if (!enable) begin
                        state_d = ST_HOLD;
                    end else if (count_q == CNT_ONE) begin
                        tc_d = 1'b1;
                        if (mode_q) begin
                            count_d = reload_q;
                            state_d = ST_RUN;
                        end else begin
                            count_d = CNT_ZERO;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        count_d = count_q - CNT_ONE;
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = CNT_ZERO;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            count_q  <= CNT_ZERO;
            reload_q <= CNT_ZERO;
            mode_q   <= 1'b0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            tc_q     <= tc_d;
        end
    end

    assign q  = count_q;
    assign tc = tc_q;

endmodule

// File: tb/tb_down_timer.sv
module tb_down_timer;

    logic        clk;
    logic        rst;
    logic        sclr;
    logic        load_valid;
    logic        load_ready;
    logic [19:0] load_value;
    logic        periodic;
    logic        enable;
    logic        stop;
    logic [19:0] q;
    logic        busy;
    logic        tc;

    // Narrow instance used to run a full max-value count in few cycles.
    logic        s_load_ready;
    logic [7:0]  s_q;
    logic        s_busy;
    logic        s_tc;

    int n_checks = 0;
    int n_errors = 0;

    down_timer #(.WIDTH(20)) dut (
        .clk(clk), .rst(rst), .sclr(sclr),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_value(load_value), .periodic(periodic),
        .enable(enable), .stop(stop),
        .q(q), .busy(busy), .tc(tc)
    );

    down_timer #(.WIDTH(8)) dut_s (
        .clk(clk), .rst(rst), .sclr(sclr),
        .load_valid(load_valid), .load_ready(s_load_ready),
        .load_value(load_value[7:0]), .periodic(periodic),
        .enable(enable), .stop(stop),
        .q(s_q), .busy(s_busy), .tc(s_tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [19:0] n, input logic per);
        load_valid = 1'b1;
        load_value = n;
        periodic   = per;
        tick();
        load_valid = 1'b0;
    endtask

    logic        p_en [11] = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,1'b1,1'b1};
    logic [19:0] p_q  [11] = '{20'd2,20'd1,20'd3,20'd3,20'd3,20'd2,20'd1,20'd3,20'd2,20'd1,20'd3};
    logic        p_tc [11] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1};
    logic [19:0] os_q [5]  = '{20'd4,20'd3,20'd2,20'd1,20'd0};

    initial begin
        int tc_seen;
        int cyc;
        rst = 1'b1; sclr = 1'b0; load_valid = 1'b0; load_value = 20'd0;
        periodic = 1'b0; enable = 1'b0; stop = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_q", q, 0);
        check_eq("rst_tc", tc, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ready", load_ready, 1);
        rst = 1'b0;
        tick();

        // Asynchronous reset in the middle of a count.
        enable = 1'b1;
        do_load(20'd10, 1'b0);
        check_eq("rm_load_q", q, 10);
        check_eq("rm_load_busy", busy, 1);
        repeat (4) tick();
        check_eq("rm_q6", q, 6);
        #2 rst = 1'b1;
        #1;
        check_eq("rm_async_q", q, 0);
        check_eq("rm_async_busy", busy, 0);
        check_eq("rm_async_tc", tc, 0);
        rst = 1'b0;
        tc_seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (tc) tc_seen++;
        end
        check_eq("rm_no_tc", tc_seen, 0);

        // One-shot N=5.
        do_load(20'd5, 1'b0);
        check_eq("os_q5", q, 5);
        check_eq("os_ready_run", load_ready, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq($sformatf("os_q_%0d", i), q, os_q[i]);
            check_eq($sformatf("os_tc_%0d", i), tc, (i == 4) ? 1 : 0);
        end
        check_eq("os_busy_end", busy, 0);
        check_eq("os_ready_end", load_ready, 1);
        tick();
        check_eq("os_tc_after", tc, 0);

        // Periodic N=3 with a two-cycle hold after the first tc.
        enable = 1'b1;
        do_load(20'd3, 1'b1);
        check_eq("per_q3", q, 3);
        for (int i = 0; i < 11; i++) begin
            enable = p_en[i];
            tick();
            check_eq($sformatf("per_q_k%0d", i + 1), q, p_q[i]);
            check_eq($sformatf("per_tc_k%0d", i + 1), tc, p_tc[i]);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_eq("per_stop_q", q, 0);
        check_eq("per_stop_busy", busy, 0);

        // Handshake: load offered in RUN is ignored, accepted in HOLD.
        enable = 1'b1;
        do_load(20'd20, 1'b0);
        load_valid = 1'b1;
        load_value = 20'd7;
        tick();
        check_eq("hs_run_q", q, 19);
        check_eq("hs_run_ready", load_ready, 0);
        enable = 1'b0;
        tick();
        check_eq("hs_hold_q", q, 19);
        check_eq("hs_hold_ready", load_ready, 1);
        tick();
        load_valid = 1'b0;
        check_eq("hs_acc_q", q, 7);
        check_eq("hs_acc_ready", load_ready, 0);
        enable = 1'b1;
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // Zero load with periodic set: single tc, then IDLE.
        do_load(20'd0, 1'b1);
        check_eq("z_q", q, 0);
        check_eq("z_busy", busy, 1);
        check_eq("z_tc0", tc, 0);
        tick();
        check_eq("z_tc1", tc, 1);
        check_eq("z_idle", busy, 0);
        tick();
        check_eq("z_tc_after", tc, 0);
        check_eq("z_q_after", q, 0);

        // Max value: 20-bit start and full 8-bit count to expiry.
        do_load(20'hFFFFF, 1'b0);
        check_eq("max_q20", q, 32'hFFFFF);
        check_eq("max_q8", s_q, 32'hFF);
        cyc = 0;
        while (!s_tc && cyc < 400) begin
            tick();
            cyc++;
        end
        check_eq("max_cycles", cyc, 255);
        check_eq("max_s_q", s_q, 0);
        check_eq("max_q20_after", q, 32'hFFF00);
        tick();
        check_eq("max_s_busy", s_busy, 0);
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // Priority: stop on the expiring edge keeps reload/mode.
        do_load(20'd2, 1'b1);
        tick();
        check_eq("pr_q1", q, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_eq("pr_stop_tc", tc, 0);
        check_eq("pr_stop_q", q, 0);
        check_eq("pr_stop_busy", busy, 0);
        check_eq("pr_stop_reload", dut.reload_q, 2);
        check_eq("pr_stop_mode", dut.mode_q, 1);

        // Priority: sclr together with stop on the expiring edge clears all.
        do_load(20'd2, 1'b1);
        tick();
        sclr = 1'b1;
        stop = 1'b1;
        tick();
        sclr = 1'b0;
        stop = 1'b0;
        check_eq("pr_sclr_tc", tc, 0);
        check_eq("pr_sclr_q", q, 0);
        check_eq("pr_sclr_reload", dut.reload_q, 0);
        check_eq("pr_sclr_mode", dut.mode_q, 0);
        tick();
        check_eq("pr_sclr_tc_after", tc, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/down_timer.md
# down_timer

Programmable down-counting timer, the load-and-expire counterpart to the free-running 20-bit up counter in the VGA/audio timing path. A consumer loads a start value through a valid/ready handshake. The block counts down on enabled cycles and pulses `tc` when the count expires. It runs either one-shot (note duration, blanking delay) or periodic (tone/tick generation), with hold, stop and synchronous clear.

## Interface
- `WIDTH`, default 20: counter and load-value width.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `sclr`  in  1  synchronous clear, same effect as reset on the next edge.
- `load_valid`  in  1  start value offered.
- `load_ready`  out  1  block can accept a load.
- `load_value`  in  WIDTH  start value N.
- `periodic`  in  1  sampled at load accept: 1 = auto-reload, 0 = one-shot.
- `enable`  in  1  count-enable qualifier.
- `stop`  in  1  abort the current count.
- `q`  out  WIDTH  current count, registered.
- `busy`  out  1  high in RUN or HOLD.
- `tc`  out  1  terminal-count pulse, one cycle, registered.

## Operation
- States:
  - IDLE: not counting; `load_ready`=1.
  - RUN: counting; `load_ready`=0.
  - HOLD: paused; `load_ready`=1.
- Internal registers: `reload` (WIDTH bits) and `mode` (1 bit), written only on load accept.
- Edge priority: `rst` > `sclr` > `stop` > load accept > count.
- `rst` or `sclr`: state IDLE; `q`=0, `reload`=0, `mode`=0, `tc`=0, `busy`=0.
- `stop` in any state: state IDLE; `q`=0; `tc`=0; `reload` and `mode` retained.
- Load accept (`load_valid` && `load_ready`, in IDLE or HOLD):
  - `reload`←N, `mode`←`periodic`, `q`←N.
  - State becomes RUN; no decrement on the accepting edge.
  - `load_valid` while `load_ready`=0 is ignored. The source must hold it until accepted.
- N=0: accepted. On the next edge `tc`=1, `q`=0 and state goes to IDLE, regardless of `mode`. Zero never free-runs.
- Count, RUN or HOLD, `enable`=1:
  - If `q`>1: `q`←`q`-1; state RUN.
  - If `q`==1: `tc`←1.
    - `mode`=0: `q`←0; state IDLE.
    - `mode`=1: `q`←`reload`; state RUN.
- Count, RUN with `enable`=0: state HOLD; `q` frozen.
- Count, HOLD with `enable`=0: remain in HOLD.
- `q` never wraps below 0. Arithmetic is unsigned, modulo-free, WIDTH bits.
- `tc` is 0 on every edge where it is not set by the rules above.

## Timing
- Reset values: `q`=0, `tc`=0, `busy`=0, `load_ready`=1.
- `busy` and `load_ready` decode from the state register, so they change the cycle after the state edge.
- Latency: the load is accepted at edge k. With `enable` held high, `tc`=1 after edge k+N, which is N cycles of load-to-expire.
- Periodic period is exactly N enabled cycles per `tc`. N=1 periodic gives `tc` on every enabled cycle.
- Each `enable`=0 cycle during a count delays `tc` by one cycle.
- A load in HOLD restarts the count from the new N. A pending expiry is discarded.
- `stop` on the same edge as a would-be `tc` wins: no `tc`, state IDLE.
- `rst` asserted mid-count clears outputs immediately, without a clock. Counting resumes only after a new load.

## Test plan
- Reset mid-count: load N=10 with `periodic`=0; assert `rst` asynchronously after 4 cycles -> `q`=0, `busy`=0, `tc`=0 immediately. No `tc` follows.
- One-shot: load N=5, `periodic`=0, `enable`=1 -> `q` reads 5,4,3,2,1,0; a single `tc` after edge k+5; state IDLE and `load_ready`=1 after that.
- Periodic with hold: load N=3, `periodic`=1; hold `enable` low for 2 cycles after the first `tc` -> `tc` at k+3, then k+8, then k+11; `q` reloads to 3 on each `tc`.
- Handshake: offer `load_value`=7 during RUN -> not accepted, `q` unaffected. Drop `enable` so the block enters HOLD -> the load is accepted there and `q`=7 on the next edge.
- Zero and max: load N=0 -> one `tc`, then IDLE, even with `periodic`=1. Load N=2^20-1 one-shot -> `tc` exactly 1048575 enabled cycles later.
- Priority: assert `stop` and `sclr` on the expiring edge -> no `tc`. After `stop`, `reload` is retained; after `sclr`, `reload`=0.
